multiword_add_sequencer: RTL

- Sequencer that performs a wide add or subtract on a single WIDTH-bit ripple_carry_adder instance, one word per clock.
- Operands are WORDS*WIDTH bits wide and are captured when start is accepted.
- The block walks the words from least-significant up, feeding the registered carry back in as the next word's carry-in, then presents the full result with carry and signed-overflow flags.
- Used wherever wide arithmetic is needed but area rules out a full-width adder.

---
 rtl/multiword_add_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: wide add/subtract done one WIDTH-bit word per clock
// on a single shared ripple_carry_adder, carry registered between words.
module ripple_carry_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   logic [WIDTH:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[WIDTH];
   assign ovf  = c[WIDTH] ^ c[WIDTH-1];
endmodule

module multiword_add_sequencer #(
   parameter int WIDTH = 4,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   op_sub,
   input  logic [WIDTH*WORDS-1:0] a,
   input  logic [WIDTH*WORDS-1:0] b,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH*WORDS-1:0] result,
   output logic                   cout,
   output logic                   ovf
);
   localparam int N  = WIDTH * WORDS;
   localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t          state;
   logic [IW-1:0]   idx;
   logic            carry, sub, co, ov, last;
   logic [N-1:0]    a_sh, b_sh, acc, acc_nx;
   logic [WIDTH-1:0] sum;
   ripple_carry_adder #(.WIDTH(WIDTH)) u_add (
      .a    (a_sh[WIDTH-1:0]),
      .b    (b_sh[WIDTH-1:0] ^ {WIDTH{sub}}),
      .cin  (carry),
      .sum  (sum),
      .cout (co),
      .ovf  (ov)
   );
   // each new word enters at the top, so after WORDS steps every word sits in place
   assign acc_nx = N'({sum, acc} >> WIDTH);
   assign last   = idx == IW'(WORDS - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         sub    <= 1'b0;
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sh  <= a;
               b_sh  <= b;
               sub   <= op_sub;
               carry <= op_sub;
               idx   <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
         end else begin
            a_sh  <= a_sh >> WIDTH;
            b_sh  <= b_sh >> WIDTH;
            acc   <= acc_nx;
            carry <= co;
            idx   <= idx + IW'(1);
            if (last) begin
               result <= acc_nx;
               cout   <= co;
               ovf    <= ov;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         end
      end
   end
endmodule
